// File: rtl/matrix_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_loader_pkg
//  Description : Shared frame geometry defaults and loader FSM state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_loader_pkg;

    // Frame geometry shared with the encoder and any other consumer
    localparam int unsigned ML_WIDTH = 25;
    localparam int unsigned ML_DEPTH = 64;

    // Launch sequencing states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENC_RST = 2'd1,
        ST_GAP     = 2'd2,
        ST_RUN     = 2'd3
    } ml_state_e;

endpackage : matrix_loader_pkg
`default_nettype wire

// File: rtl/matrix_loader_line_bank.sv
`default_nettype none
// ============================================================================
//  Module      : line_bank
//  Description : DEPTH x WIDTH register array, one write port and one
//                combinational read port. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_bank
    import matrix_loader_pkg::*;
#(
    parameter  int unsigned WIDTH = ML_WIDTH,
    parameter  int unsigned DEPTH = ML_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Line storage write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Zero-latency read port
    assign rdata_o = mem_q[raddr_i];

endmodule : line_bank
`default_nettype wire

// File: rtl/matrix_loader.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_loader
//  Description : Ping-pong frame loader feeding encoder_top. Collects lines
//                from a valid/ready stream into two banks and sequences the
//                encoder reset / start for each full bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_loader
    import matrix_loader_pkg::*;
#(
    parameter  int unsigned WIDTH      = ML_WIDTH,
    parameter  int unsigned DEPTH      = ML_DEPTH,
    parameter  int unsigned RST_CYCLES = 2,
    parameter  int unsigned GAP_CYCLES = 2,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             enc_rst,
    output logic             start,
    input  logic             done,
    input  logic [AW-1:0]    cnt_value,
    output logic [WIDTH-1:0] line_in,
    output logic [15:0]      frames_done
);

    // Phase counter only has to span the longer of the two timed phases
    localparam int unsigned C_PH_MAX = (RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES;
    localparam int unsigned C_PH_W   = (C_PH_MAX > 1) ? $clog2(C_PH_MAX) : 1;

    ml_state_e          state_q, state_d;
    logic [C_PH_W-1:0]  phase_q, phase_d;
    logic [1:0]         full_q, full_d;
    logic               wr_bank_q, wr_bank_d;
    logic [AW-1:0]      wr_cnt_q, wr_cnt_d;
    logic               rd_bank_q, rd_bank_d;
    logic [15:0]        frames_q, frames_d;
    logic               enc_rst_q;
    logic               start_q;

    logic               w_accept;
    logic               w_clr_full;
    logic [1:0]         w_we;
    logic [AW-1:0]      w_raddr;
    logic [WIDTH-1:0]   w_rdata [2];

    assign in_ready = ~full_q[wr_bank_q];
    assign w_accept = in_valid & in_ready;
    assign w_we     = {w_accept & wr_bank_q, w_accept & ~wr_bank_q};

    // The encoder's counter points at the line it just consumed; serve the
    // next one, wrapping from the last line back to line 0.
    assign w_raddr  = cnt_value + AW'(1);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        line_bank #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_bank (
            .clk     (clk),
            .we_i    (w_we[b]),
            .waddr_i (wr_cnt_q),
            .wdata_i (in_data),
            .raddr_i (w_raddr),
            .rdata_o (w_rdata[b])
        );
    end

    assign line_in     = w_rdata[rd_bank_q];
    assign enc_rst     = enc_rst_q;
    assign start       = start_q;
    assign frames_done = frames_q;

    // Launch sequencing: wait for a full read bank, reset, gap, run to done
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        rd_bank_d  = rd_bank_q;
        frames_d   = frames_q;
        w_clr_full = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = ST_ENC_RST;
                    phase_d = '0;
                end
            end
            ST_ENC_RST: begin
                if (phase_q == C_PH_W'(RST_CYCLES - 1)) begin
                    state_d = ST_GAP;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + C_PH_W'(1);
                end
            end
            ST_GAP: begin
                if (phase_q == C_PH_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + C_PH_W'(1);
                end
            end
            ST_RUN: begin
                if (done) begin
                    state_d    = ST_IDLE;
                    w_clr_full = 1'b1;
                    rd_bank_d  = ~rd_bank_q;
                    frames_d   = frames_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Write side bookkeeping; set and clear of full never hit the same bank
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        if (w_accept) begin
            wr_cnt_d = wr_cnt_q + AW'(1);
            if (wr_cnt_q == AW'(DEPTH - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_cnt_d          = '0;
            end
        end
        if (w_clr_full) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    // State registers; outputs are registered from the next state so they
    // are glitch-free and enc_rst can be held high during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            frames_q  <= 16'd0;
            enc_rst_q <= 1'b1;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_bank_q <= rd_bank_d;
            frames_q  <= frames_d;
            enc_rst_q <= (state_d == ST_ENC_RST);
            start_q   <= (state_d == ST_RUN);
        end
    end

endmodule : matrix_loader
`default_nettype wire

// File: doc/matrix_loader.md
# matrix_loader

Upstream feeder for `encoder_top`. It accepts 25-bit matrix lines over a valid/ready stream and collects them into one of two 64-line banks (ping-pong), so the next frame can load while the encoder runs. When a bank is full, it pulses the encoder's reset, raises `start`, and serves `line_in` combinationally from the active bank, indexed by the encoder's `cnt_value`. This replaces the per-file `$readmemb` loading and the manual reset/start sequencing used in simulation.

## Interface
- `WIDTH`, default 25: line width in bits.
- `DEPTH`, default 64: lines per frame. Must be a power of 2. `AW = log2(DEPTH)` = 6.
- `RST_CYCLES`, default 2: number of cycles `enc_rst` is held high before each frame.
- `GAP_CYCLES`, default 2: number of idle cycles between `enc_rst` falling and `start` rising.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: an input line is offered.
- `in_ready`, out, 1: the loader can accept a line.
- `in_data`, in, WIDTH: line data. Lines arrive in frame order, line 0 first.
- `enc_rst`, out, 1: synchronous reset to the encoder.
- `start`, out, 1: encoder start, held as a level.
- `done`, in, 1: the encoder's `donee` level.
- `cnt_value`, in, AW: the encoder's line counter.
- `line_in`, out, WIDTH: equals `bank[rd_bank][(cnt_value+1) mod DEPTH]`.
- `frames_done`, out, 16: count of completed frames. Wraps at 2^16.

## Operation
- Storage: `bank[2][DEPTH]` of WIDTH-bit registers. Contents are not reset.
- Registered state: `full[1:0]`, `wr_bank`, `wr_cnt[AW-1:0]`, `rd_bank`, FSM state, and a phase counter.
- Write side:
  - `in_ready = ~full[wr_bank]`.
  - On each accept (`in_valid & in_ready`): `bank[wr_bank][wr_cnt] <= in_data` and `wr_cnt++`.
  - On the accept where `wr_cnt == DEPTH-1`: set `full[wr_bank]`, toggle `wr_bank`, and wrap `wr_cnt` to 0.
- Read address: `cnt_value+1` computed in AW bits, so it wraps naturally (63 maps to 0). `line_in` is purely combinational from the address and `rd_bank`.
- FSM states and transitions:
  - **IDLE**: `start=0`, `enc_rst=0`. Moves to ENC_RST when `full[rd_bank]`.
  - **ENC_RST**: `enc_rst=1` for RST_CYCLES cycles, then moves to GAP.
  - **GAP**: both outputs low for GAP_CYCLES cycles, then moves to RUN.
  - **RUN**: `start=1` until `done` is sampled high. On that edge: move to IDLE, clear `full[rd_bank]`, toggle `rd_bank`, and increment `frames_done`.
- The encoder is not reset on completion. `done` and its results stay valid until the next frame launches. The falling edge of `done` (caused by `enc_rst`) marks the start of the next frame.
- `done` is ignored outside RUN.
- Simultaneous set and clear of `full` always targets different banks, because `wr_bank==rd_bank` with that bank full implies `in_ready=0`.

## Timing
- Reset values, applied asynchronously while `rst` is high:
  - `in_ready=1`, `enc_rst=1`, `start=0`.
  - `frames_done=0`, `full=0`, `wr_bank=rd_bank=0`, `wr_cnt=0`.
  - FSM in IDLE. `enc_rst` drops at the first clock edge after reset is released.
- Launch latency: let the last line be accepted at edge E.
  - `enc_rst` is high from edge E+1 through E+RST_CYCLES.
  - `start` rises at edge E+RST_CYCLES+GAP_CYCLES+1 (E+5 with defaults).
- Completion: `done` is sampled high at edge D.
  - At D: `start=0`, `frames_done+1`, and `full[rd_bank]` is cleared.
  - `in_ready` may rise in the cycle after D.
  - If the other bank is already full, `enc_rst` rises at edge D+1.
- `line_in` has zero latency relative to `cnt_value` and `rd_bank`.
- Reset during mid-operation (any state) aborts the current frame and discards both banks' `full` flags. No handshake is completed.

## Structure
- A shared package holds the FSM state enum (IDLE, ENC_RST, GAP, RUN) and defaults for WIDTH and DEPTH, so downstream blocks agree on frame geometry.
- Sub-module `line_bank`: one DEPTH×WIDTH register array with one write port and one combinational read port, instantiated twice.

## Test plan
- **Reset:** hold `rst` for 3 cycles → `enc_rst=1`, `start=0`, `in_ready=1`, `frames_done=0`. One edge after release → `enc_rst=0`.
- **Single frame:** push `in_data=i` for i=0..63 back-to-back → `enc_rst` high for 2 cycles starting at E+1, `start=1` at E+5. `cnt_value=5` → `line_in=6`. `cnt_value=63` → `line_in=0`.
- **Double buffer:** push 128 lines with `done` held low → `in_ready=0` after line 127 is accepted. Raise `done` → `start=0`, `frames_done=1`, `in_ready=1` one cycle later, `enc_rst=1` at D+1, and `line_in` is served from bank 1 (`cnt_value=0` → line 65).
- **Stalled input:** random `in_valid` gaps over 64 lines → identical `line_in` mapping and identical launch timing relative to the last accept.
- **Spurious done:** pulse `done` while in IDLE or GAP → no state change, `frames_done` unchanged.
- **Mid-RUN reset:** assert `rst` in RUN → `start=0` and `enc_rst=1` immediately (asynchronous). After release: `in_ready=1` and no launch until 64 new lines are accepted.
